// File: rtl/otn_map_pkg.sv
// Shared types and constants for the OTN frame mapper slice: region
// classification, FAS bytes, default frame geometry and the scrambler
// polynomial/seed with its byte-parallel step helpers.
package otn_map_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    REG_FAS,
    REG_MFAS,
    REG_OH,
    REG_STUFF,
    REG_PAYLOAD
  } region_e;

  localparam int    DEF_NUM_ROWS  = 4;
  localparam int    DEF_NUM_COLS  = 1041;
  localparam int    DEF_OH_COLS   = 16;
  localparam int    DEF_STUFF_COL = 1040;
  localparam int    DEF_MFAS_COL  = 6;
  localparam byte_t DEF_FAS_A     = 8'hF6;
  localparam byte_t DEF_FAS_B     = 8'h28;

  // FAS occupies row 0 columns 0..5; the first three carry byte A.
  localparam int FAS_A_COLS = 3;
  localparam int FAS_COLS   = 6;

  // x^16 + x^12 + x^3 + x + 1, feedback taps below the x^16 term.
  localparam logic [15:0] SCR_POLY = 16'h100B;
  localparam logic [15:0] SCR_SEED = 16'hFFFF;

  // Eight serial LFSR steps; the key is the MSB stream, first bit in key[7].
  function automatic byte_t scr_key_byte(input logic [15:0] state);
    logic [15:0] s;
    byte_t       key;
    s   = state;
    key = '0;
    for (int i = 0; i < 8; i++) begin
      key[7-i] = s[15];
      s = s[15] ? ({s[14:0], 1'b0} ^ SCR_POLY) : {s[14:0], 1'b0};
    end
    return key;
  endfunction

  // LFSR state after the same eight steps that produce one key byte.
  function automatic logic [15:0] scr_advance8(input logic [15:0] state);
    logic [15:0] s;
    s = state;
    for (int i = 0; i < 8; i++) begin
      s = s[15] ? ({s[14:0], 1'b0} ^ SCR_POLY) : {s[14:0], 1'b0};
    end
    return s;
  endfunction

endpackage

// File: rtl/otn_frame_mapper_if.sv
// Client payload ready/valid handshake between the payload source (master)
// and the frame mapper (slave).
interface otn_frame_mapper_if
  import otn_map_pkg::*;
  ;
  byte_t pyld_data;
  logic  pyld_data_valid;
  logic  pyld_ready;

  modport master (output pyld_data, output pyld_data_valid, input pyld_ready);
  modport slave  (input pyld_data, input pyld_data_valid, output pyld_ready);
endinterface

// File: rtl/otn_frame_scrambler.sv
// Frame-synchronous byte-parallel scrambler. The key for the current byte
// comes from the seed when preset is high, otherwise from the running state;
// the state moves on by eight bits only on enabled bytes.
module otn_frame_scrambler
  import otn_map_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  en_i,
  input  logic  preset_i,
  output byte_t key_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;
  logic [15:0] base;

  // Pick the preset or running state, derive the key and the next state.
  always_comb begin
    base    = preset_i ? SCR_SEED : state_q;
    key_o   = scr_key_byte(base);
    state_d = en_i ? scr_advance8(base) : state_q;
  end

  // LFSR state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= SCR_SEED;
    else         state_q <= state_d;
  end

endmodule

// File: rtl/otn_frame_mapper.sv
// Self-timed OTN frame mapper: owns row/column/MFAS counters, inserts FAS,
// MFAS, zero overhead and a stuff column, and pulls client payload through a
// ready/valid handshake. One registered line byte per enabled cycle.
// Optional build macro FRAME_SCRAMBLE_EN adds the frame-synchronous scrambler.
module otn_frame_mapper
  import otn_map_pkg::*;
#(
  parameter int    NUM_ROWS   = DEF_NUM_ROWS,
  parameter int    NUM_COLS   = DEF_NUM_COLS,
  parameter int    OH_COLS    = DEF_OH_COLS,
  parameter int    STUFF_COL  = DEF_STUFF_COL,
  parameter byte_t FAS_BYTE_A = DEF_FAS_A,
  parameter byte_t FAS_BYTE_B = DEF_FAS_B,
  parameter int    MFAS_COL   = DEF_MFAS_COL
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  otn_frame_mapper_if.slave           pyld,
  output byte_t                       o_frame_data,
  output logic                        o_frame_data_valid,
  output logic                        o_frame_data_fas,
  output logic [$clog2(NUM_ROWS)-1:0] o_row_cnt,
  output logic [$clog2(NUM_COLS)-1:0] o_col_cnt,
  output byte_t                       o_mfas,
  output logic                        o_underrun
);

  localparam int RW = $clog2(NUM_ROWS);
  localparam int CW = $clog2(NUM_COLS);

  localparam logic [RW-1:0] ROW_LAST  = RW'(NUM_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(NUM_COLS - 1);
  localparam logic [CW-1:0] OH_LIM    = CW'(OH_COLS);
  localparam logic [CW-1:0] STUFF_C   = CW'(STUFF_COL);
  localparam logic [CW-1:0] MFAS_C    = CW'(MFAS_COL);
  localparam logic [CW-1:0] FAS_A_END = CW'(FAS_A_COLS);
  localparam logic [CW-1:0] FAS_END   = CW'(FAS_COLS);

  logic [RW-1:0] row_q, row_d, row_out_q, row_out_d;
  logic [CW-1:0] col_q, col_d, col_out_q, col_out_d;
  byte_t         mfas_q, mfas_d;
  byte_t         data_q, data_d;
  logic          valid_q, fas_q, fas_d, underrun_q, underrun_d;
  region_e       region;
  byte_t         raw_byte;
  byte_t         line_byte;

  // Advance the frame position on enabled cycles; MFAS counts whole frames.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    mfas_d = mfas_q;
    if (i_en) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d  = '0;
          mfas_d = mfas_q + 8'd1;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Classify the current position and build the unscrambled line byte.
  always_comb begin
    region = REG_PAYLOAD;
    if (row_q == '0 && col_q < FAS_END)        region = REG_FAS;
    else if (row_q == '0 && col_q == MFAS_C)   region = REG_MFAS;
    else if (col_q < OH_LIM)                   region = REG_OH;
    else if (col_q == STUFF_C)                 region = REG_STUFF;

    raw_byte = '0;
    case (region)
      REG_FAS:     raw_byte = (col_q < FAS_A_END) ? FAS_BYTE_A : FAS_BYTE_B;
      REG_MFAS:    raw_byte = mfas_q;
      REG_PAYLOAD: raw_byte = pyld.pyld_data_valid ? pyld.pyld_data : 8'h00;
      default:     raw_byte = '0;
    endcase
  end

  assign pyld.pyld_ready = i_en & (region == REG_PAYLOAD) & pyld.pyld_data_valid;

`ifdef FRAME_SCRAMBLE_EN
  byte_t scr_key;

  otn_frame_scrambler u_scrambler (
    .clk_i    (i_clk),
    .rst_ni   (i_rst),
    .en_i     (i_en),
    .preset_i (region == REG_MFAS),
    .key_o    (scr_key)
  );

  assign line_byte = (region == REG_FAS) ? raw_byte : (raw_byte ^ scr_key);
`else
  assign line_byte = raw_byte;
`endif

  // Output stage next state: byte and its position load only on enabled cycles.
  always_comb begin
    data_d     = data_q;
    row_out_d  = row_out_q;
    col_out_d  = col_out_q;
    fas_d      = 1'b0;
    underrun_d = 1'b0;
    if (i_en) begin
      data_d     = line_byte;
      row_out_d  = row_q;
      col_out_d  = col_q;
      fas_d      = (row_q == '0) && (col_q == '0);
      underrun_d = (region == REG_PAYLOAD) && !pyld.pyld_data_valid;
    end
  end

  // Position counters and registered output stage.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      row_q      <= '0;
      col_q      <= '0;
      mfas_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      fas_q      <= 1'b0;
      underrun_q <= 1'b0;
      row_out_q  <= '0;
      col_out_q  <= '0;
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      mfas_q     <= mfas_d;
      data_q     <= data_d;
      valid_q    <= i_en;
      fas_q      <= fas_d;
      underrun_q <= underrun_d;
      row_out_q  <= row_out_d;
      col_out_q  <= col_out_d;
    end
  end

  assign o_frame_data       = data_q;
  assign o_frame_data_valid = valid_q;
  assign o_frame_data_fas   = fas_q;
  assign o_row_cnt          = row_out_q;
  assign o_col_cnt          = col_out_q;
  assign o_mfas             = mfas_q;
  assign o_underrun         = underrun_q;

endmodule

// File: tb/tb_otn_frame_mapper.sv
// Directed self-checking bench for otn_frame_mapper. A second, small-geometry
// instance is used to reach the MFAS wrap in a short run.
module tb_otn_frame_mapper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN;
  logic        en;
  logic [7:0]  frameData, sData, mfasO, sMfas;
  logic        frameValid, frameFas, underrun, sValid, sFas, sUnder;
  logic [1:0]  rowCnt;
  logic [10:0] colCnt;
  logic [0:0]  sRow;
  logic [4:0]  sCol;

  otn_frame_mapper_if pyldIf ();
  otn_frame_mapper_if pyldIfS ();
  assign pyldIfS.pyld_data       = pyldIf.pyld_data;
  assign pyldIfS.pyld_data_valid = pyldIf.pyld_data_valid;

  otn_frame_mapper dut (
    .i_clk(clk), .i_rst(rstN), .i_en(en), .pyld(pyldIf),
    .o_frame_data(frameData), .o_frame_data_valid(frameValid),
    .o_frame_data_fas(frameFas), .o_row_cnt(rowCnt), .o_col_cnt(colCnt),
    .o_mfas(mfasO), .o_underrun(underrun)
  );

  otn_frame_mapper #(.NUM_ROWS(2), .NUM_COLS(20), .OH_COLS(16), .STUFF_COL(19)) dutSmall (
    .i_clk(clk), .i_rst(rstN), .i_en(en), .pyld(pyldIfS),
    .o_frame_data(sData), .o_frame_data_valid(sValid),
    .o_frame_data_fas(sFas), .o_row_cnt(sRow), .o_col_cnt(sCol),
    .o_mfas(sMfas), .o_underrun(sUnder)
  );

  int          checks;
  int          failures;
  int          mRow, mCol, consumed;
  logic [7:0]  mMfas, payCnt, expData;
  logic [15:0] mScr;
  logic        expReady, obsReady, expFas, expUnder, expValid;
  logic [1:0]  expRow;
  logic [10:0] expCol;

  // Reference scrambler: returns {key byte, next state} after eight bits.
  function automatic logic [23:0] refScr(input logic [15:0] s0);
    logic [15:0] s;
    logic [7:0]  k;
    logic        fb;
    s = s0;
    k = 8'h00;
    for (int i = 0; i < 8; i++) begin
      fb = s[15];
      k  = {k[6:0], fb};
      s  = {s[14:0], 1'b0};
      if (fb) begin
        s[12] = ~s[12]; s[3] = ~s[3]; s[1] = ~s[1]; s[0] = ~s[0];
      end
    end
    return {k, s};
  endfunction

  task automatic resetModel();
    mRow = 0; mCol = 0; mMfas = 8'h00; mScr = 16'hFFFF;
    expData = 8'h00; expRow = 2'd0; expCol = 11'd0;
  endtask

  task automatic doReset();
    rstN = 1'b0; en = 1'b0;
    pyldIf.pyld_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;
    resetModel();
  endtask

  // One clock: drive inputs, sample ready, predict outputs, advance the model.
  task automatic cycle(input logic enV, input logic vldV);
    logic [7:0]  raw;
    logic        isPay;
    logic [23:0] r;
    en = enV;
    pyldIf.pyld_data_valid = vldV;
    pyldIf.pyld_data = payCnt;
    #1;
    isPay    = (mCol >= 16) && (mCol != 1040);
    expReady = enV & isPay & vldV;
    obsReady = pyldIf.pyld_ready;
    expValid = enV;
    expFas   = 1'b0;
    expUnder = 1'b0;
    if (enV) begin
      if (mRow == 0 && mCol < 3)       raw = 8'hF6;
      else if (mRow == 0 && mCol < 6)  raw = 8'h28;
      else if (mRow == 0 && mCol == 6) raw = mMfas;
      else if (!isPay)                 raw = 8'h00;
      else                             raw = vldV ? payCnt : 8'h00;
      if (mRow == 0 && mCol == 6) mScr = 16'hFFFF;
      r = refScr(mScr);
      mScr = r[15:0];
`ifdef FRAME_SCRAMBLE_EN
      if (!(mRow == 0 && mCol < 6)) raw = raw ^ r[23:16];
`endif
      expData  = raw;
      expFas   = (mRow == 0) && (mCol == 0);
      expUnder = isPay & ~vldV;
      expRow   = 2'(mRow);
      expCol   = 11'(mCol);
    end
    @(posedge clk);
    #1;
    if (expReady) begin
      payCnt = payCnt + 8'd1;
      consumed++;
    end
    if (enV) begin
      if (mCol == 1040) begin
        mCol = 0;
        if (mRow == 3) begin mRow = 0; mMfas = mMfas + 8'd1; end
        else mRow++;
      end else begin
        mCol++;
      end
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0; en = 1'b1;
    pyldIf.pyld_data_valid = 1'b1; pyldIf.pyld_data = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (frameData !== 8'h00) begin failures++; $display("[TB] FAIL reset_data got=%h exp=00", frameData); end
    checks++; if (frameValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", frameValid); end
    checks++; if (frameFas !== 1'b0) begin failures++; $display("[TB] FAIL reset_fas got=%b exp=0", frameFas); end
    checks++; if ({rowCnt, colCnt} !== 13'd0) begin failures++; $display("[TB] FAIL reset_pos got=%0d/%0d exp=0/0", rowCnt, colCnt); end
    checks++; if (mfasO !== 8'h00) begin failures++; $display("[TB] FAIL reset_mfas got=%h exp=00", mfasO); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_underrun got=%b exp=0", underrun); end
    checks++; if (pyldIf.pyld_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=0", pyldIf.pyld_ready); end
  endtask

  task automatic test_first_frame();
    logic [7:0] fasTab [6];
    fasTab = '{8'hF6, 8'hF6, 8'hF6, 8'h28, 8'h28, 8'h28};
    doReset();
    payCnt = 8'h00;
    consumed = 0;
    for (int n = 0; n < 2 * 4164 + 7; n++) begin
      cycle(1'b1, 1'b1);
      checks++; if (frameData !== expData) begin failures++; $display("[TB] FAIL ff_data n=%0d got=%h exp=%h", n, frameData, expData); end
      checks++; if (obsReady !== expReady) begin failures++; $display("[TB] FAIL ff_ready n=%0d got=%b exp=%b", n, obsReady, expReady); end
      checks++; if (frameFas !== expFas) begin failures++; $display("[TB] FAIL ff_fas n=%0d got=%b exp=%b", n, frameFas, expFas); end
      checks++; if (frameValid !== 1'b1) begin failures++; $display("[TB] FAIL ff_valid n=%0d got=%b exp=1", n, frameValid); end
      checks++; if ({rowCnt, colCnt} !== {expRow, expCol}) begin failures++; $display("[TB] FAIL ff_pos n=%0d got=%0d/%0d exp=%0d/%0d", n, rowCnt, colCnt, expRow, expCol); end
      checks++; if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL ff_underrun n=%0d got=%b exp=0", n, underrun); end
      if (n < 6) begin
        checks++; if (frameData !== fasTab[n]) begin failures++; $display("[TB] FAIL ff_fas_byte n=%0d got=%h exp=%h", n, frameData, fasTab[n]); end
      end
`ifndef FRAME_SCRAMBLE_EN
      if (n == 6 || n == 15 || n == 16) begin
        checks++; if (frameData !== 8'h00) begin failures++; $display("[TB] FAIL ff_zero_byte n=%0d got=%h exp=00", n, frameData); end
      end
      if (expCol == 11'd1040) begin
        checks++; if (frameData !== 8'h00) begin failures++; $display("[TB] FAIL ff_stuff n=%0d got=%h exp=00", n, frameData); end
      end
      if (n == 4170) begin
        checks++; if (frameData !== 8'h01) begin failures++; $display("[TB] FAIL ff_mfas2_byte got=%h exp=01", frameData); end
      end
`endif
      if (n == 100) begin
        checks++; if (mfasO !== 8'h00) begin failures++; $display("[TB] FAIL ff_mfas0 got=%h exp=00", mfasO); end
      end
      if (n == 4163) begin
        checks++; if (consumed !== 4096) begin failures++; $display("[TB] FAIL ff_consumed got=%0d exp=4096", consumed); end
      end
      if (n == 4170) begin
        checks++; if (mfasO !== 8'h01) begin failures++; $display("[TB] FAIL ff_mfas1 got=%h exp=01", mfasO); end
      end
    end
  endtask

  task automatic test_underrun();
    doReset();
    payCnt = 8'h40;
    repeat (20) cycle(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0);
      checks++; if (underrun !== 1'b1) begin failures++; $display("[TB] FAIL ur_pulse k=%0d got=%b exp=1", k, underrun); end
      checks++; if (obsReady !== 1'b0) begin failures++; $display("[TB] FAIL ur_ready k=%0d got=%b exp=0", k, obsReady); end
      checks++; if (colCnt !== 11'(20 + k)) begin failures++; $display("[TB] FAIL ur_col k=%0d got=%0d exp=%0d", k, colCnt, 20 + k); end
      checks++; if (frameData !== expData) begin failures++; $display("[TB] FAIL ur_data k=%0d got=%h exp=%h", k, frameData, expData); end
`ifndef FRAME_SCRAMBLE_EN
      checks++; if (frameData !== 8'h00) begin failures++; $display("[TB] FAIL ur_zero k=%0d got=%h exp=00", k, frameData); end
`endif
    end
    cycle(1'b1, 1'b1);
    checks++; if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL ur_end_pulse got=%b exp=0", underrun); end
    checks++; if (obsReady !== 1'b1) begin failures++; $display("[TB] FAIL ur_end_ready got=%b exp=1", obsReady); end
    checks++; if (colCnt !== 11'd23) begin failures++; $display("[TB] FAIL ur_end_col got=%0d exp=23", colCnt); end
`ifndef FRAME_SCRAMBLE_EN
    checks++; if (frameData !== 8'h44) begin failures++; $display("[TB] FAIL ur_end_data got=%h exp=44", frameData); end
`endif
  endtask

  task automatic test_en_toggle();
    logic [7:0] prevData;
    for (int k = 0; k < 10; k++) begin
      prevData = frameData;
      cycle((k % 2) == 0, 1'b1);
      checks++; if (frameValid !== ((k % 2) == 0)) begin failures++; $display("[TB] FAIL en_valid k=%0d got=%b", k, frameValid); end
      checks++; if (colCnt !== 11'(24 + k / 2)) begin failures++; $display("[TB] FAIL en_col k=%0d got=%0d exp=%0d", k, colCnt, 24 + k / 2); end
      checks++; if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL en_underrun k=%0d got=%b exp=0", k, underrun); end
      if (k % 2 == 1) begin
        checks++; if (frameData !== prevData) begin failures++; $display("[TB] FAIL en_hold k=%0d got=%h exp=%h", k, frameData, prevData); end
      end else begin
        checks++; if (frameData !== expData) begin failures++; $display("[TB] FAIL en_data k=%0d got=%h exp=%h", k, frameData, expData); end
      end
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    repeat (4164 + 2 * 1041 + 500) cycle(1'b1, 1'b1);
    checks++; if ({rowCnt, colCnt} !== {2'd2, 11'd499}) begin failures++; $display("[TB] FAIL rm_pos got=%0d/%0d exp=2/499", rowCnt, colCnt); end
    checks++; if (mfasO !== 8'h01) begin failures++; $display("[TB] FAIL rm_mfas_pre got=%h exp=01", mfasO); end
    en = 1'b1;
    #2;
    rstN = 1'b0;
    #1;
    checks++; if ({frameData, frameValid, frameFas, underrun} !== 11'd0) begin failures++; $display("[TB] FAIL rm_outs got=%h/%b/%b/%b exp=0", frameData, frameValid, frameFas, underrun); end
    checks++; if ({rowCnt, colCnt, mfasO} !== 21'd0) begin failures++; $display("[TB] FAIL rm_cnts got=%0d/%0d/%h exp=0", rowCnt, colCnt, mfasO); end
    @(posedge clk);
    #1;
    rstN = 1'b1;
    resetModel();
    cycle(1'b1, 1'b1);
    checks++; if (frameData !== 8'hF6) begin failures++; $display("[TB] FAIL rm_first got=%h exp=F6", frameData); end
    checks++; if (frameFas !== 1'b1) begin failures++; $display("[TB] FAIL rm_fas got=%b exp=1", frameFas); end
    checks++; if (mfasO !== 8'h00) begin failures++; $display("[TB] FAIL rm_mfas got=%h exp=00", mfasO); end
    checks++; if ({rowCnt, colCnt} !== 13'd0) begin failures++; $display("[TB] FAIL rm_pos0 got=%0d/%0d exp=0/0", rowCnt, colCnt); end
  endtask

  task automatic test_mfas_wrap();
    doReset();
    repeat (255 * 40) cycle(1'b1, 1'b1);
    checks++; if (sMfas !== 8'hFF) begin failures++; $display("[TB] FAIL wrap_255 got=%h exp=FF", sMfas); end
    repeat (40) cycle(1'b1, 1'b1);
    checks++; if (sMfas !== 8'h00) begin failures++; $display("[TB] FAIL wrap_0 got=%h exp=00", sMfas); end
    repeat (7) cycle(1'b1, 1'b1);
    checks++; if ({sRow, sCol} !== 6'd6) begin failures++; $display("[TB] FAIL wrap_pos got=%0d/%0d exp=0/6", sRow, sCol); end
    checks++; if ({sValid, sFas, sUnder} !== 3'b100) begin failures++; $display("[TB] FAIL wrap_flags got=%b%b%b exp=100", sValid, sFas, sUnder); end
`ifndef FRAME_SCRAMBLE_EN
    checks++; if (sData !== 8'h00) begin failures++; $display("[TB] FAIL wrap_mfas_byte got=%h exp=00", sData); end
`endif
  endtask

  initial begin
    checks = 0;
    failures = 0;
    payCnt = 8'h00;
    consumed = 0;
    resetModel();
    test_reset();
    test_first_frame();
    test_underrun();
    test_en_toggle();
    test_reset_mid();
    test_mfas_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
